// File: rtl/bus_datapath_seq.sv
// Bus-sequenced datapath: a register file, Y/Z/HI/LO registers and a single shared
// internal bus, all sequenced by a small FSM (IDLE, T1..T4, DONE).
module bus_datapath_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREGS   = 16,
    parameter bit          R0_ZERO = 1'b1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rc,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    input  logic             ext_wr_en,
    input  logic [AW-1:0]    ext_wr_addr,
    input  logic [WIDTH-1:0] ext_wr_data,
    output logic             ext_wr_rej,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] bus_out
);

    localparam int unsigned ZW  = 2 * WIDTH;
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] y_q, y_d;
    logic [ZW-1:0]    z_q, z_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    rb_q, rb_d;
    logic [AW-1:0]    rc_q, rc_d;
    logic             rej_q, rej_d;

    logic             we_c;
    logic [AW-1:0]    waddr_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] src_b_c;
    logic [WIDTH-1:0] src_c_c;
    logic [WIDTH-1:0] bus_c;
    logic [WIDTH-1:0] res_c;
    logic [ZW-1:0]    mul_c;
    logic [ZW-1:0]    z_next_c;
    logic [SHW-1:0]   sh_c;

    // Register-file reads; R0 reads as zero when hard-wired.
    assign src_b_c = (R0_ZERO && (rb_q == '0)) ? '0 : regs_q[rb_q];
    assign src_c_c = (R0_ZERO && (rc_q == '0)) ? '0 : regs_q[rc_q];
    assign rd_data = (R0_ZERO && (rd_addr == '0)) ? '0 : regs_q[rd_addr];

    // Shared bus: exactly one source per state, zero when undriven.
    always_comb begin
        bus_c = '0;
        unique case (state_q)
            S_T1:    bus_c = src_b_c;
            S_T2:    bus_c = src_c_c;
            S_T3:    bus_c = z_q[WIDTH-1:0];
            S_T4:    bus_c = z_q[ZW-1:WIDTH];
            default: bus_c = '0;
        endcase
    end

    // ALU: Y against the bus; only the low shift bits count.
    always_comb begin
        sh_c  = bus_c[SHW-1:0];
        mul_c = ZW'(y_q) * ZW'(bus_c);
        res_c = '0;
        unique case (op_q)
            OP_ADD:  res_c = y_q + bus_c;
            OP_SUB:  res_c = y_q - bus_c;
            OP_AND:  res_c = y_q & bus_c;
            OP_OR:   res_c = y_q | bus_c;
            OP_SHL:  res_c = y_q << sh_c;
            OP_SHR:  res_c = y_q >> sh_c;
            default: res_c = '0;
        endcase
        z_next_c = {{WIDTH{1'b0}}, res_c};
        if (op_q == OP_MUL) begin
            z_next_c = mul_c;
        end else if (op_q == OP_RSV) begin
            z_next_c = z_q;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        y_d     = y_q;
        z_d     = z_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_c    = 1'b0;
        waddr_c = ext_wr_addr;
        wdata_c = ext_wr_data;
        rej_d   = ext_wr_en && (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                we_c = ext_wr_en;
                if (start) begin
                    op_d    = op;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                y_d     = bus_c;
                state_d = S_T2;
            end
            S_T2: begin
                z_d     = z_next_c;
                state_d = S_T3;
            end
            S_T3: begin
                if (op_q == OP_MUL) begin
                    lo_d    = bus_c;
                    state_d = S_T4;
                end else if (op_q == OP_RSV) begin
                    state_d = S_DONE;
                end else begin
                    we_c    = 1'b1;
                    waddr_c = ra_q;
                    wdata_c = bus_c;
                    state_d = S_DONE;
                end
            end
            S_T4: begin
                hi_d    = bus_c;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and latched-operand registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            y_q   <= '0;
            z_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            rej_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            z_q   <= z_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            op_q  <= op_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            rc_q  <= rc_d;
            rej_q <= rej_d;
        end
    end

    // Register file: single write port shared by external loads and T3 results.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_c && !(R0_ZERO && (waddr_c == '0))) begin
            regs_q[waddr_c] <= wdata_c;
        end
    end

    // Status and observation outputs decoded from registered state.
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign illegal    = (state_q == S_DONE) && (op_q == OP_RSV);
    assign ext_wr_rej = rej_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign bus_out    = bus_c;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Scoreboard bench for bus_datapath_seq: stimulus pushes expected completions,
// a monitor pops them on every done pulse.
module tb_bus_datapath_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        busy, done, illegal;
    logic        ext_wr_en;
    logic [3:0]  ext_wr_addr;
    logic [31:0] ext_wr_data;
    logic        ext_wr_rej;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data, hi_out, lo_out, bus_out;

    bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .busy(busy), .done(done), .illegal(illegal),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .ext_wr_rej(ext_wr_rej), .rd_addr(rd_addr), .rd_data(rd_data),
        .hi_out(hi_out), .lo_out(lo_out), .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m[16];
    logic [31:0] m_hi, m_lo;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int done_cnt = 0, rej_cnt = 0, exp_rej = 0, n_issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mr(input logic [3:0] a);
        return (a == 4'd0) ? 32'h0 : m[a];
    endfunction

    function automatic void mw(input logic [3:0] a, input logic [31:0] v);
        if (a != 4'd0) m[a] = v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ext_wr_rej === 1'b1) rej_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op");
                end else begin
                    e = sbq.pop_front();
                    check("illegal", {63'h0, illegal}, {63'h0, e.ill});
                    check("hi_out", {32'h0, hi_out}, {32'h0, e.hi});
                    check("lo_out", {32'h0, lo_out}, {32'h0, e.lo});
                    check("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
            end else if (illegal === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL illegal_without_done: got illegal=1, expected 0");
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b0) return;
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: got busy=%b, expected 0 within 30 cycles", busy);
    endtask

    task automatic ext_wr(input logic [3:0] a, input logic [31:0] d);
        wait_idle();
        ext_wr_en   = 1'b1;
        ext_wr_addr = a;
        ext_wr_data = d;
        mw(a, d);
        @(posedge clk);
        #1;
        ext_wr_en = 1'b0;
    endtask

    // Issue one operation, optionally poking ext write in T1 / start in T2.
    task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input bit inj_ext, input bit inj_start);
        exp_t        e;
        logic [31:0] x, y, res;
        logic [63:0] p;
        wait_idle();
        x   = mr(b);
        y   = mr(c);
        res = 32'h0;
        case (o)
            3'd0: res = x + y;
            3'd1: res = x - y;
            3'd2: res = x & y;
            3'd3: res = x | y;
            3'd4: res = x << (y % 32);
            3'd5: res = x >> (y % 32);
            default: res = 32'h0;
        endcase
        if (o == 3'd6) begin
            p    = {32'h0, x} * {32'h0, y};
            m_lo = p[31:0];
            m_hi = p[63:32];
        end else if (o != 3'd7) begin
            mw(a, res);
        end
        e.ill   = (o == 3'd7);
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.issue = cyc + 1;
        e.lat   = (o == 3'd6) ? 4 : 3;
        sbq.push_back(e);
        n_issued++;
        start = 1'b1;
        op    = o;
        ra    = a;
        rb    = b;
        rc    = c;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ext_wr_en = 1'b0;
        op        = 3'($urandom);
        ra        = 4'($urandom);
        rb        = 4'($urandom);
        rc        = 4'($urandom);
        check("bus_t1", {32'h0, bus_out}, {32'h0, x});
        if (inj_ext) begin
            ext_wr_en   = 1'b1;
            ext_wr_addr = 4'd5;
            ext_wr_data = $urandom;
            exp_rej++;
        end
        @(posedge clk);
        #1;
        if (inj_ext) begin
            ext_wr_en = 1'b0;
            check("ext_wr_rej", {63'h0, ext_wr_rej}, 64'h1);
        end
        if (inj_start) begin
            start = 1'b1;
            op    = 3'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_idle();
        rd_addr = a;
        #1;
        check("reg_ra", {32'h0, rd_data}, {32'h0, mr(a)});
        if (inj_ext) begin
            rd_addr = 4'd5;
            #1;
            check("reg_r5", {32'h0, rd_data}, {32'h0, mr(4'd5)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        clr = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_hi", {32'h0, hi_out}, 64'h0);
        check("rst_lo", {32'h0, lo_out}, 64'h0);
        clr = 1'b0;
        check("idle_bus", {32'h0, bus_out}, 64'h0);

        // Abort an ADD mid-flight with clr during T2.
        ext_wr(4'd1, 32'd5);
        ext_wr(4'd2, 32'd7);
        start = 1'b1; op = 3'd0; ra = 4'd3; rb = 4'd1; rc = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_done", {63'h0, done}, 64'h0);
        rd_addr = 4'd1;
        #1;
        check("abort_r1", {32'h0, rd_data}, 64'h0);
        rd_addr = 4'd3;
        #1;
        check("abort_r3", {32'h0, rd_data}, 64'h0);
        model_reset();
        dc = done_cnt;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(dc));

        // Start on the first edge after reset release.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        do_op(3'd0, 4'd6, 4'd1, 4'd1, 1'b0, 1'b0);

        ext_wr(4'd1, 32'd5);
        ext_wr(4'd2, 32'd7);
        do_op(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0);
        ext_wr(4'd1, 32'd3);
        ext_wr(4'd2, 32'd5);
        do_op(3'd1, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0);
        ext_wr(4'd1, 32'd1);
        ext_wr(4'd2, 32'd33);
        do_op(3'd4, 4'd6, 4'd1, 4'd2, 1'b0, 1'b0);
        ext_wr(4'd1, 32'hFFFF_FFFF);
        ext_wr(4'd2, 32'd2);
        ext_wr(4'd7, 32'h1234_5678);
        do_op(3'd6, 4'd7, 4'd1, 4'd2, 1'b0, 1'b0);
        do_op(3'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
        do_op(3'd2, 4'd8, 4'd1, 4'd2, 1'b0, 1'b1);
        ext_wr(4'd5, 32'h55);
        do_op(3'd3, 4'd9, 4'd5, 4'd2, 1'b1, 1'b0);
        do_op(3'd7, 4'd10, 4'd1, 4'd2, 1'b0, 1'b0);
        do_op(3'd5, 4'd12, 4'd1, 4'd2, 1'b0, 1'b0);

        // External write and start in the same IDLE cycle.
        wait_idle();
        ext_wr_en = 1'b1; ext_wr_addr = 4'd2; ext_wr_data = 32'h100;
        mw(4'd2, 32'h100);
        do_op(3'd0, 4'd11, 4'd1, 4'd2, 1'b0, 1'b0);
        do_op(3'd0, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);

        ext_wr(4'd0, 32'hDEAD_BEEF);
        rd_addr = 4'd0;
        #1;
        check("r0_zero", {32'h0, rd_data}, 64'h0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0)
                ext_wr(4'($urandom_range(0, 15)), $urandom);
            do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt), 64'(n_issued));
        check("rej_count", 64'(rej_cnt), 64'(exp_rej));
        check("sb_empty", 64'(sbq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
